// File: rtl/seq_sub_comparator.sv
// Multi-cycle subtract-based comparator: computes a - b = a + ~b + 1 DIGIT bits
// per cycle from the LSB, then reports diff, z/n/c/v and signed/unsigned lt/eq/gt.
module seq_sub_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             lt,
    output logic             eq,
    output logic             gt
);
    localparam int NSTEP  = WIDTH / DIGIT;
    localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, nb_reg, diff_reg, diff_next;
    logic              sm_reg, carry_reg;
    logic [STEP_W-1:0] step_reg;
    logic              z_reg, n_reg, c_reg, v_reg, lt_reg, gt_reg;

    logic [DIGIT-1:0]  a_slice  [NSTEP];
    logic [DIGIT-1:0]  nb_slice [NSTEP];
    logic [DIGIT-1:0]  cur_a, cur_nb;
    logic [DIGIT:0]    sum;
    logic              last_step;
    logic              c_msb_in, z_fin, n_fin, v_fin, lt_fin;

    // Operand slices and the in-place diff update, one lane per step.
    for (genvar gi = 0; gi < NSTEP; gi++) begin : g_slice
        assign a_slice[gi]  = a_reg[gi*DIGIT +: DIGIT];
        assign nb_slice[gi] = nb_reg[gi*DIGIT +: DIGIT];
        assign diff_next[gi*DIGIT +: DIGIT] =
            (step_reg == STEP_W'(gi)) ? sum[DIGIT-1:0] : diff_reg[gi*DIGIT +: DIGIT];
    end

    assign cur_a     = a_slice[step_reg];
    assign cur_nb    = nb_slice[step_reg];
    assign sum       = {1'b0, cur_a} + {1'b0, cur_nb} + {{DIGIT{1'b0}}, carry_reg};
    assign last_step = (step_reg == STEP_W'(NSTEP - 1));

    // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
    assign c_msb_in = sum[DIGIT-1] ^ cur_a[DIGIT-1] ^ cur_nb[DIGIT-1];
    assign z_fin    = ~|diff_next;
    assign n_fin    = diff_next[WIDTH-1];
    assign v_fin    = c_msb_in ^ sum[DIGIT];
    assign lt_fin   = sm_reg ? (n_fin ^ v_fin) : ~sum[DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            nb_reg    <= '0;
            diff_reg  <= '0;
            sm_reg    <= 1'b0;
            carry_reg <= 1'b0;
            step_reg  <= '0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
            c_reg     <= 1'b0;
            v_reg     <= 1'b0;
            lt_reg    <= 1'b0;
            gt_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        nb_reg    <= ~b;
                        sm_reg    <= signed_md;
                        carry_reg <= 1'b1;
                        step_reg  <= '0;
                    end
                end
                RUN: begin
                    diff_reg  <= diff_next;
                    carry_reg <= sum[DIGIT];
                    step_reg  <= step_reg + 1'b1;
                    if (last_step) begin
                        z_reg  <= z_fin;
                        n_reg  <= n_fin;
                        c_reg  <= sum[DIGIT];
                        v_reg  <= v_fin;
                        lt_reg <= lt_fin;
                        gt_reg <= ~lt_fin & ~z_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign z         = z_reg;
    assign n         = n_reg;
    assign c         = c_reg;
    assign v         = v_reg;
    assign lt        = lt_reg;
    assign eq        = z_reg;
    assign gt        = gt_reg;
endmodule

// File: tb/tb_seq_sub_comparator.sv
// Runs three comparator instances (DIGIT = 4, 1, 16) side by side on the same
// operands and checks latency, handshake and results against an arithmetic model.
module tb_seq_sub_comparator;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, sm_in;
    logic [W-1:0] a_in, b_in;

    logic [2:0] in_ready_w, out_valid_w, z_w, n_w, c_w, v_w, lt_w, eq_w, gt_w;
    logic [W-1:0] diff_w [3];

    int total = 0;
    int bad   = 0;
    int lat [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    seq_sub_comparator #(.WIDTH(W), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .a(a_in), .b(b_in), .signed_md(sm_in), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .diff(diff_w[0]), .z(z_w[0]), .n(n_w[0]),
        .c(c_w[0]), .v(v_w[0]), .lt(lt_w[0]), .eq(eq_w[0]), .gt(gt_w[0]));

    seq_sub_comparator #(.WIDTH(W), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .a(a_in), .b(b_in), .signed_md(sm_in), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .diff(diff_w[1]), .z(z_w[1]), .n(n_w[1]),
        .c(c_w[1]), .v(v_w[1]), .lt(lt_w[1]), .eq(eq_w[1]), .gt(gt_w[1]));

    seq_sub_comparator #(.WIDTH(W), .DIGIT(16)) dut_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .a(a_in), .b(b_in), .signed_md(sm_in), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .diff(diff_w[2]), .z(z_w[2]), .n(n_w[2]),
        .c(c_w[2]), .v(v_w[2]), .lt(lt_w[2]), .eq(eq_w[2]), .gt(gt_w[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected flags packed as {z,n,c,v,lt,eq,gt}, from integer comparisons.
    function automatic logic [6:0] model_flags(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        logic [W-1:0] d;
        logic fz, fn, fc, fv, flt, feq, fgt;
        d   = ta - tb;
        fz  = (d == '0);
        fn  = d[W-1];
        fc  = (ta >= tb);
        fv  = (ta[W-1] != tb[W-1]) && (d[W-1] != ta[W-1]);
        flt = ts ? ($signed(ta) < $signed(tb)) : (ta < tb);
        feq = (ta == tb);
        fgt = ts ? ($signed(ta) > $signed(tb)) : (ta > tb);
        return {fz, fn, fc, fv, flt, feq, fgt};
    endfunction

    function automatic logic [6:0] obs_flags(input int i);
        return {z_w[i], n_w[i], c_w[i], v_w[i], lt_w[i], eq_w[i], gt_w[i]};
    endfunction

    task automatic check_idle_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_in_ready_u%0d", tag, i), 32'(in_ready_w[i]), 32'd1);
            check($sformatf("%s_out_valid_u%0d", tag, i), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("%s_diff_u%0d", tag, i), 32'(diff_w[i]), 32'd0);
            check($sformatf("%s_flags_u%0d", tag, i), 32'(obs_flags(i)), 32'd0);
        end
    endtask

    task automatic do_cmp(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input int hold);
        logic [6:0]   ef;
        logic [W-1:0] ed;
        ef = model_flags(ta, tb, ts);
        ed = ta - tb;
        a_in = ta; b_in = tb; sm_in = ts; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); sm_in = ~ts;
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_busy_u%0d", tag, i), 32'(in_ready_w[i]), 32'd0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("%s_ov_u%0d_k%0d", tag, i, k), 32'(out_valid_w[i]), 32'(k >= lat[i]));
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_diff_u%0d", tag, i), 32'(diff_w[i]), 32'(ed));
            check($sformatf("%s_flags_u%0d", tag, i), 32'(obs_flags(i)), 32'(ef));
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a_in = W'($urandom); b_in = W'($urandom); sm_in = 1'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_hold%0d_ov_u%0d", tag, h, i), 32'(out_valid_w[i]), 32'd1);
                check($sformatf("%s_hold%0d_ir_u%0d", tag, h, i), 32'(in_ready_w[i]), 32'd0);
                check($sformatf("%s_hold%0d_diff_u%0d", tag, h, i), 32'(diff_w[i]), 32'(ed));
                check($sformatf("%s_hold%0d_flags_u%0d", tag, h, i), 32'(obs_flags(i)), 32'(ef));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_rel_ov_u%0d", tag, i), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("%s_rel_ir_u%0d", tag, i), 32'(in_ready_w[i]), 32'd1);
        end
        $display("cmp %s a=%04h b=%04h signed=%0d diff=%04h flags(zncv/lt/eq/gt)=%07b",
                 tag, ta, tb, ts, ed, ef);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sm_in = 1'b0; a_in = '0; b_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_reset("reset");

        do_cmp("equal_u",    16'h0005, 16'h0005, 1'b0, 0);
        do_cmp("less_u",     16'h0003, 16'h0007, 1'b0, 0);
        do_cmp("ovf_s",      16'h7FFF, 16'hFFFF, 1'b1, 0);
        do_cmp("ovf_u",      16'h7FFF, 16'hFFFF, 1'b0, 0);
        do_cmp("neg_ovf_s",  16'h8000, 16'h0001, 1'b1, 0);
        do_cmp("backpress",  16'h0003, 16'h0007, 1'b0, 5);

        // Abort a compare on its second RUN cycle; nothing may surface later.
        a_in = 16'h0003; b_in = 16'h0007; sm_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_reset("abort");
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                check($sformatf("abort_quiet_u%0d_k%0d", i, k), 32'(out_valid_w[i]), 32'd0);
        end
        $display("abort mid-run: reset applied on second RUN cycle");
        do_cmp("after_abort", 16'h0003, 16'h0007, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            ra = pick_operand();
            rb = (t % 7 == 0) ? ra : pick_operand();
            do_cmp($sformatf("rand%0d", t), ra, rb, 1'($urandom), (t % 10 == 3) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_sub_comparator.md
Name: seq_sub_comparator

Overview:
Parametrised, multi-cycle successor to the team's 4-bit subtract-based comparator (z/n/v flags). It compares two WIDTH-bit operands by computing a - b as a + ~b + 1, processing DIGIT bits per cycle from the LSB with a registered carry. It reports the full difference, the flags z/n/c/v, and decoded lt/eq/gt in signed or unsigned mode. It sits between an operand source and a consumer, with a valid/ready handshake on each side.

Parameters:
WIDTH, 16, operand width in bits; WIDTH >= 2.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0.
(derived) NSTEP = WIDTH/DIGIT, number of RUN cycles.

Ports:
clk        in   1      rising-edge clock
rst        in   1      synchronous, active-high reset
in_valid   in   1      operand pair valid
in_ready   out  1      block can accept operands
a          in   WIDTH  minuend
b          in   WIDTH  subtrahend
signed_md  in   1      1 = two's-complement compare, 0 = unsigned; sampled with a/b
out_valid  out  1      result valid
out_ready  in   1      consumer accepts result
diff       out  WIDTH  a - b mod 2^WIDTH
z          out  1      diff == 0
n          out  1      diff[WIDTH-1]
c          out  1      carry out of MSB (1 = a >= b unsigned)
v          out  1      signed overflow = carry into MSB XOR carry out of MSB
lt         out  1      a < b under the latched mode
eq         out  1      a == b (equals z)
gt         out  1      a > b under the latched mode

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; diff, z, n, c, v, lt, eq, gt all 0; internal carry, step counter and operand registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On a clock edge with in_valid=1, latch a, b and signed_md, set carry=1 and step=0, then go to RUN. With in_valid=0, stay in IDLE.
- RUN: in_ready=0 and out_valid=0.
  - Each cycle, add the slice {a,~b}[DIGIT*step +: DIGIT] with the registered carry. Write the sum bits into diff, either in place or shifted in from the top (implementer's choice; final diff must be exact).
  - On the last step (step == NSTEP-1), capture the carry into bit WIDTH-1 (c_msb_in) and the carry out (c).
  - After NSTEP cycles, go to DONE.
- Latency: out_valid goes high exactly NSTEP cycles after the accepting edge. With defaults that is 4 cycles.
- Flags, all registered on entry to DONE:
  - z = ~|diff
  - n = diff[WIDTH-1]
  - v = c_msb_in ^ c
  - lt = signed_md_q ? (n ^ v) : ~c
  - eq = z
  - gt = ~lt & ~z
- DONE:
  - out_valid=1, in_ready=0.
  - All result outputs hold stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. Result outputs keep their last values; they are only meaningful while out_valid=1.
- No overlap: a new operand is accepted only in IDLE, so back-to-back throughput is one compare per NSTEP+2 cycles.
- Changes to a, b or signed_md outside the accepting edge have no effect.
- DIGIT == WIDTH: NSTEP=1, so the block is a single RUN cycle.
- DIGIT == 1: pure bit-serial operation; v is still taken from the MSB carries.
- Reset during RUN or DONE: on the next edge, return to IDLE with reset values. The in-flight compare is discarded and never produces out_valid.
- rst has priority over in_valid and out_ready on the same edge.
- Arithmetic is modulo 2^WIDTH. No saturation. No X propagation from unused operand bits.

Test Plan:
(WIDTH=16, DIGIT=4 unless stated)
1. a=0x0005, b=0x0005, unsigned -> out_valid 4 cycles after accept; diff=0x0000, z=1, n=0, c=1, v=0, eq=1, lt=0, gt=0.
2. a=0x0003, b=0x0007, unsigned -> diff=0xFFFC, z=0, n=1, c=0, v=0, lt=1, gt=0.
3. a=0x7FFF, b=0xFFFF: signed -> diff=0x8000, n=1, v=1, c=0, lt=0, gt=1 (32767 > -1). Same operands unsigned -> lt=1, gt=0.
4. a=0x8000, b=0x0001, signed -> diff=0x7FFF, n=0, v=1, c=1, lt=1, gt=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff and flags unchanged, in_ready=0. Pulsing in_valid with new operands has no effect. Then out_ready=1 -> IDLE next cycle, in_ready=1.
6. Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, all flags 0. No out_valid appears for the aborted compare. Repeat scenario 2 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) -> identical results.
